osc_freq_cal: RTL and testbench



---
 rtl/osc_freq_cal_if.sv | 25 ++
 rtl/osc_freq_cal.sv | 186 ++++++++++++++++++
 tb/tb_osc_freq_cal.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/osc_freq_cal_if.sv
// Control and status bundle between the calibration loop and its host/oscillator side.
interface osc_freq_cal_if #(
    parameter int CNT_W = 12
);
    logic             glob_en;
    logic             cal_start;
    logic             osc_pulse;
    logic [CNT_W-1:0] target_cnt;
    logic [6:0]       delay_con_msb;
    logic [3:0]       delay_con_lsb;
    logic [CNT_W-1:0] meas_cnt;
    logic             cal_busy;
    logic             cal_lock;
    logic             cal_err;

    modport master (
        output glob_en, cal_start, osc_pulse, target_cnt,
        input  delay_con_msb, delay_con_lsb, meas_cnt, cal_busy, cal_lock, cal_err
    );

    modport slave (
        input  glob_en, cal_start, osc_pulse, target_cnt,
        output delay_con_msb, delay_con_lsb, meas_cnt, cal_busy, cal_lock, cal_err
    );
endinterface

// File: rtl/osc_freq_cal.sv
// Ring-oscillator frequency calibration: coarse then fine binary search on the
// delay codes, followed by continuous +/-1 fine-code tracking.
module osc_freq_cal #(
    parameter int CNT_W   = 12,
    parameter int WIN_CYC = 1024,
    parameter int TOL     = 1
) (
    input logic           clk,
    input logic           rst_n,
    osc_freq_cal_if.slave bus
);
    localparam int               WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);
    localparam logic [2:0]       C_INIT   = 3'd4;
    localparam logic [3:0]       F_INIT   = 4'd8;

    typedef enum logic [1:0] {IDLE, CSRCH, FSRCH, TRACK} state_t;
    typedef enum logic [1:0] {SETTLE, MEASURE, DECIDE} phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic [2:0]       c_q, c_d;
    logic [3:0]       f_q, f_d;
    logic [1:0]       k_q, k_d;
    logic             busy_q, busy_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [6:0]       msb_q;

    logic             win_end;
    logic [CNT_W-1:0] pulse_inc;
    logic             too_fast;
    logic [CNT_W:0]   meas_x;
    logic [CNT_W:0]   hi_x;
    logic [CNT_W:0]   lo_x;

    function automatic logic [6:0] therm(input logic [2:0] c);
        therm = 7'((8'd1 << c) - 8'd1);
    endfunction

    // Band limits are formed one bit wider so target+TOL cannot wrap and target-TOL floors at zero.
    always_comb begin
        win_end   = (win_q == WIN_LAST);
        pulse_inc = (pulse_q == '1) ? pulse_q : pulse_q + CNT_W'(bus.osc_pulse);
        too_fast  = (meas_q > bus.target_cnt);
        meas_x    = {1'b0, meas_q};
        hi_x      = {1'b0, bus.target_cnt} + TOL_X;
        lo_x      = ({1'b0, bus.target_cnt} >= TOL_X) ? ({1'b0, bus.target_cnt} - TOL_X) : '0;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        win_d   = win_q;
        pulse_d = pulse_q;
        meas_d  = meas_q;
        c_d     = c_q;
        f_d     = f_q;
        k_d     = k_q;
        busy_d  = busy_q;
        lock_d  = lock_q;
        err_d   = err_q;

        if (!bus.glob_en) begin
            state_d = IDLE;
            phase_d = SETTLE;
            win_d   = '0;
            pulse_d = '0;
            c_d     = C_INIT;
            f_d     = F_INIT;
            k_d     = 2'd2;
            busy_d  = 1'b0;
            lock_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.cal_start) begin
                state_d = CSRCH;
                phase_d = SETTLE;
                win_d   = '0;
                pulse_d = '0;
                c_d     = C_INIT;
                f_d     = F_INIT;
                k_d     = 2'd2;
                busy_d  = 1'b1;
                lock_d  = 1'b0;
                err_d   = 1'b0;
            end
        end else begin
            case (phase_q)
                SETTLE, MEASURE: begin
                    if (win_end) begin
                        win_d   = '0;
                        pulse_d = '0;
                        meas_d  = pulse_inc;
                        phase_d = (phase_q == SETTLE) ? MEASURE : DECIDE;
                    end else begin
                        win_d   = win_q + WIN_W'(1);
                        pulse_d = pulse_inc;
                    end
                end
                default: begin
                    // Codes only change here, once per settle+measure+decide evaluation.
                    phase_d = SETTLE;
                    win_d   = '0;
                    pulse_d = '0;
                    case (state_q)
                        CSRCH: begin
                            if (!too_fast) c_d[k_q] = 1'b0;
                            if (k_q != 2'd0) begin
                                c_d[k_q - 2'd1] = 1'b1;
                                k_d             = k_q - 2'd1;
                            end else begin
                                state_d = FSRCH;
                                f_d     = F_INIT;
                                k_d     = 2'd3;
                            end
                        end
                        FSRCH: begin
                            if (!too_fast) f_d[k_q] = 1'b0;
                            if (k_q != 2'd0) begin
                                f_d[k_q - 2'd1] = 1'b1;
                                k_d             = k_q - 2'd1;
                            end else begin
                                state_d = TRACK;
                                busy_d  = 1'b0;
                            end
                        end
                        default: begin
                            if (meas_x > hi_x) begin
                                lock_d = 1'b0;
                                if (f_q == 4'd15) err_d = 1'b1;
                                else              f_d   = f_q + 4'd1;
                            end else if (meas_x < lo_x) begin
                                lock_d = 1'b0;
                                if (f_q == 4'd0) err_d = 1'b1;
                                else             f_d   = f_q - 4'd1;
                            end else begin
                                lock_d = 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= SETTLE;
            win_q   <= '0;
            pulse_q <= '0;
            meas_q  <= '0;
            c_q     <= C_INIT;
            f_q     <= F_INIT;
            k_q     <= 2'd2;
            busy_q  <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            msb_q   <= 7'b0001111;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            win_q   <= win_d;
            pulse_q <= pulse_d;
            meas_q  <= meas_d;
            c_q     <= c_d;
            f_q     <= f_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            msb_q   <= therm(c_d);
        end
    end

    assign bus.delay_con_msb = msb_q;
    assign bus.delay_con_lsb = f_q;
    assign bus.meas_cnt      = meas_q;
    assign bus.cal_busy      = busy_q;
    assign bus.cal_lock      = lock_q;
    assign bus.cal_err       = err_q;
endmodule

// File: tb/tb_osc_freq_cal.sv
// Randomized bench for osc_freq_cal: an arithmetic binary-search/tracking model
// decides the pulse count of each window and predicts codes and status.
module tb_osc_freq_cal;
    localparam int CNT_W = 12;
    localparam int WIN   = 64;
    localparam int TOL   = 1;

    logic clk = 1'b0;
    logic rst_n;

    osc_freq_cal_if #(.CNT_W(CNT_W)) bus ();

    osc_freq_cal #(.CNT_W(CNT_W), .WIN_CYC(WIN), .TOL(TOL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_c, m_f, m_meas;
    bit m_lock, m_err;

    // Scenario 0 is a plausible oscillator: more delay gives fewer pulses per window.
    function automatic int gcount(input int scen, input int c, input int f);
        case (scen)
            0:       return 60 - 6 * c - f;
            1:       return WIN;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] thermo(input int c);
        int t;
        t = (1 << c) - 1;
        return t[6:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic checkState(input string tag, input int exp_meas, input bit exp_busy);
        checkOutput($sformatf("%s.msb", tag), 32'(bus.delay_con_msb), 32'(thermo(m_c)));
        checkOutput($sformatf("%s.lsb", tag), 32'(bus.delay_con_lsb), 32'(m_f));
        checkOutput($sformatf("%s.meas", tag), 32'(bus.meas_cnt), 32'(exp_meas));
        checkOutput($sformatf("%s.busy", tag), 32'(bus.cal_busy), 32'(exp_busy));
        checkOutput($sformatf("%s.lock", tag), 32'(bus.cal_lock), 32'(m_lock));
        checkOutput($sformatf("%s.err", tag), 32'(bus.cal_err), 32'(m_err));
    endtask

    // One evaluation: settle window, measure window (both with n pulses at a random spot), decide cycle.
    task automatic applyStimulus(input int n, input int start_at);
        int r;
        for (int w = 0; w < 2; w++) begin
            r = $urandom_range(WIN - n, 0);
            for (int j = 0; j < WIN; j++) begin
                bus.cal_start = (w * WIN + j == start_at);
                bus.osc_pulse = (j >= r) && (j < r + n);
                @(negedge clk);
            end
        end
        bus.cal_start = 1'b0;
        bus.osc_pulse = (n == WIN);
        @(negedge clk);
        bus.osc_pulse = 1'b0;
        m_meas = n;
    endtask

    task automatic runSearch(input int scen, input int target, input int busy_eval, input int n_evals);
        int acc, trial, n, ev;
        bus.target_cnt = CNT_W'(target);
        bus.cal_start  = 1'b1;
        bus.osc_pulse  = 1'b0;
        @(negedge clk);
        m_c = 4; m_f = 8; m_lock = 1'b0; m_err = 1'b0;
        ev  = 0;
        acc = 0;
        for (int k = 2; k >= 0; k--) begin
            if (ev >= n_evals) return;
            trial = acc | (1 << k);
            n = gcount(scen, trial, 8);
            applyStimulus(n, (busy_eval == ev) ? WIN / 2 : -1);
            ev++;
            if (n > target) acc = trial;
            m_c = (k > 0) ? (acc | (1 << (k - 1))) : acc;
            checkState($sformatf("s%0d.t%0d.csrch%0d", scen, target, k), n, 1'b1);
        end
        acc = 0;
        for (int k = 3; k >= 0; k--) begin
            if (ev >= n_evals) return;
            trial = acc | (1 << k);
            n = gcount(scen, m_c, trial);
            applyStimulus(n, (busy_eval == ev) ? WIN / 2 : -1);
            ev++;
            if (n > target) acc = trial;
            m_f = (k > 0) ? (acc | (1 << (k - 1))) : acc;
            checkState($sformatf("s%0d.t%0d.fsrch%0d", scen, target, k), n, (k > 0));
        end
    endtask

    task automatic runTrack(input int scen, input int target, input int evals);
        int n, lo;
        lo = (target > TOL) ? target - TOL : 0;
        for (int e = 0; e < evals; e++) begin
            n = gcount(scen, m_c, m_f);
            applyStimulus(n, -1);
            if (n > target + TOL) begin
                m_lock = 1'b0;
                if (m_f == 15) m_err = 1'b1;
                else           m_f++;
            end else if (n < lo) begin
                m_lock = 1'b0;
                if (m_f == 0) m_err = 1'b1;
                else          m_f--;
            end else begin
                m_lock = 1'b1;
            end
            checkState($sformatf("s%0d.t%0d.track%0d", scen, target, e), n, 1'b0);
        end
    endtask

    task automatic goIdle();
        bus.glob_en = 1'b0;
        @(negedge clk);
        bus.glob_en = 1'b1;
        m_c = 4; m_f = 8; m_lock = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.glob_en    = 1'b1;
        bus.cal_start  = 1'b0;
        bus.osc_pulse  = 1'b0;
        bus.target_cnt = '0;
        m_c = 4; m_f = 8; m_lock = 1'b0; m_err = 1'b0; m_meas = 0;

        #12 rst_n = 1'b0;
        #1 checkState("reset", 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        runSearch(0, 30, -1, 7);
        checkOutput("nominal.c3", 32'(bus.delay_con_msb), 32'h07);
        checkOutput("nominal.f11", 32'(bus.delay_con_lsb), 32'd11);
        runTrack(0, 30, 2);
        goIdle();

        for (int i = 0; i < 4; i++) begin
            int t;
            t = $urandom_range(45, 8);
            runSearch(0, t, -1, 7);
            runTrack(0, t, 2);
            goIdle();
        end

        // Enable drop halfway into the first fine settle window.
        runSearch(0, 30, -1, 3);
        for (int j = 0; j < WIN / 2; j++) begin
            bus.osc_pulse = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        bus.osc_pulse = 1'b0;
        bus.glob_en   = 1'b0;
        bus.cal_start = 1'b1;
        @(negedge clk);
        m_c = 4; m_f = 8; m_lock = 1'b0;
        checkState("en_drop", m_meas, 1'b0);
        @(negedge clk);
        bus.cal_start = 1'b0;
        bus.glob_en   = 1'b1;
        @(negedge clk);
        checkState("en_drop.start_ignored", m_meas, 1'b0);
        runSearch(0, 30, 4, 7);
        runTrack(0, 30, 1);
        goIdle();

        // Pulse on the last settle cycle, then on the first measure cycle.
        bus.cal_start = 1'b1;
        @(negedge clk);
        for (int j = 0; j < WIN; j++) begin
            bus.cal_start = 1'b0;
            bus.osc_pulse = (j == WIN - 1);
            @(negedge clk);
        end
        checkOutput("win_last_cycle", 32'(bus.meas_cnt), 32'd1);
        for (int j = 0; j < WIN; j++) begin
            bus.osc_pulse = (j == 0);
            @(negedge clk);
        end
        bus.osc_pulse = 1'b0;
        checkOutput("win_first_cycle", 32'(bus.meas_cnt), 32'd1);
        m_meas = 1;
        goIdle();

        runSearch(2, 4, -1, 7);
        runTrack(2, 4, 1);
        goIdle();
        checkState("idle_err_hold", m_meas, 1'b0);

        runSearch(1, 4, -1, 7);
        runTrack(1, 4, 1);

        @(posedge clk);
        #3 rst_n = 1'b0;
        m_c = 4; m_f = 8; m_lock = 1'b0; m_err = 1'b0;
        #1 checkState("async_reset", 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
